// File: rtl/frame_capture_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_capture_pkg : shared types and constants for frame_capture_ctrl |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
package frame_capture_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    PASS     = 2'd2,
    DROP     = 2'd3
  } state_t;

  localparam logic [1:0] MODE_STOP   = 2'd0;
  localparam logic [1:0] MODE_CONT   = 2'd1;
  localparam logic [1:0] MODE_SINGLE = 2'd2;

  localparam int DEF_DATA_W     = 10;
  localparam int DEF_LINE_CNT_W = 10;
  localparam int DEF_FCNT_W     = 16;
  localparam int WIDTH_CNT_W    = 12;

endpackage
`default_nettype wire

// File: rtl/frame_capture_ctrl_axis_out_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axis_out_reg : single-entry AXI-Stream output register               |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module axis_out_reg #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         full
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q && ready) valid_d = 1'b0;
    // A load in the same cycle as a drain keeps the register valid.
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign full  = valid_q & ~ready;

endmodule
`default_nettype wire

// File: rtl/frame_capture_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_capture_ctrl : frame-aligned capture sequencer for VDMA writes  |
// | Option: FRAME_CAPTURE_CTRL_LINE_STATS_EN adds line width statistics   |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module frame_capture_ctrl
  import frame_capture_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LINE_CNT_W = DEF_LINE_CNT_W,
  parameter int FCNT_W     = DEF_FCNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_W-1:0]     s_axis_tdata,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_W-1:0]     m_axis_tdata,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  input  logic [1:0]            ctrl_mode,
  input  logic                  ctrl_start,
  input  logic [LINE_CNT_W-1:0] cfg_height,
  input  logic [7:0]            cfg_skip,
  input  logic                  status_clear,
  output logic                  busy,
  output logic [FCNT_W-1:0]     frame_count,
  output logic                  err_short,
  output logic                  err_overflow
`ifdef FRAME_CAPTURE_CTRL_LINE_STATS_EN
  ,
  output logic [WIDTH_CNT_W-1:0] last_width,
  output logic                   err_width
`endif
);

  state_t                state_q, state_d;
  logic [7:0]            skip_q, skip_d;
  logic [LINE_CNT_W-1:0] line_q, line_d;
  logic                  single_q, single_d;
  logic [FCNT_W-1:0]     fcnt_q, fcnt_d;
  logic                  err_short_q, err_short_d;
  logic                  err_ovf_q, err_ovf_d;

  logic                  sof;
  logic                  mode_stop;
  logic [LINE_CNT_W-1:0] height_eff;
  logic                  take_sof;
  logic                  fwd;
  logic                  first;
  logic [LINE_CNT_W-1:0] line_base;
  logic [LINE_CNT_W-1:0] line_next;
  logic                  load;
  logic                  out_full;

`ifdef FRAME_CAPTURE_CTRL_LINE_STATS_EN
  logic [WIDTH_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [WIDTH_CNT_W-1:0] first_w_q, first_w_d;
  logic [WIDTH_CNT_W-1:0] last_w_q, last_w_d;
  logic [WIDTH_CNT_W-1:0] cur_w;
  logic                   err_width_q, err_width_d;
`endif

  assign sof        = s_axis_tvalid & s_axis_tuser;
  assign mode_stop  = (ctrl_mode != MODE_CONT) && (ctrl_mode != MODE_SINGLE);
  assign height_eff = (cfg_height == '0) ? {{(LINE_CNT_W-1){1'b0}}, 1'b1} : cfg_height;

  always_comb begin
    state_d     = state_q;
    skip_d      = skip_q;
    line_d      = line_q;
    single_d    = single_q;
    fcnt_d      = fcnt_q;
    err_short_d = err_short_q;
    err_ovf_d   = err_ovf_q;
    take_sof    = 1'b0;
    fwd         = 1'b0;
    first       = 1'b0;
    load        = 1'b0;
    line_base   = line_q;
    line_next   = line_q;
`ifdef FRAME_CAPTURE_CTRL_LINE_STATS_EN
    beat_cnt_d  = beat_cnt_q;
    first_w_d   = first_w_q;
    last_w_d    = last_w_q;
    err_width_d = err_width_q;
    cur_w       = '0;
`endif

    case (state_q)
      IDLE: begin
        if (ctrl_mode == MODE_CONT) begin
          state_d = WAIT_SOF;
          skip_d  = 8'd0;
        end else if (ctrl_mode == MODE_SINGLE && ctrl_start) begin
          state_d  = WAIT_SOF;
          skip_d   = 8'd0;
          single_d = 1'b1;
        end
      end
      WAIT_SOF: begin
        if (mode_stop) state_d = IDLE;
        else if (sof)  take_sof = 1'b1;
      end
      PASS: begin
        if (sof) begin
          err_short_d = 1'b1;
          if (mode_stop) state_d = IDLE;
          else           take_sof = 1'b1;
        end else if (s_axis_tvalid) begin
          fwd = 1'b1;
        end
      end
      default: begin
        if (sof) begin
          if (mode_stop) state_d = IDLE;
          else           take_sof = 1'b1;
        end
      end
    endcase

    // Frame-start decision shared by WAIT_SOF, DROP and the short-frame restart.
    if (take_sof) begin
      if (skip_q == 8'd0) begin
        fwd   = 1'b1;
        first = 1'b1;
      end else begin
        skip_d  = skip_q - 8'd1;
        state_d = WAIT_SOF;
      end
    end

    if (fwd) begin
      if (out_full) begin
        err_ovf_d = 1'b1;
        state_d   = DROP;
      end else begin
        load      = 1'b1;
        line_base = first ? '0 : line_q;
        line_next = line_base + 1'b1;
        if (first) begin
          skip_d  = cfg_skip;
          line_d  = '0;
          state_d = PASS;
        end
        if (s_axis_tlast) begin
          if (line_next == height_eff) begin
            fcnt_d  = fcnt_q + 1'b1;
            line_d  = '0;
            state_d = (single_q || ctrl_mode != MODE_CONT) ? IDLE : WAIT_SOF;
          end else begin
            line_d = line_next;
          end
        end
`ifdef FRAME_CAPTURE_CTRL_LINE_STATS_EN
        cur_w = (first ? '0 : beat_cnt_q) + 1'b1;
        if (s_axis_tlast) begin
          last_w_d   = cur_w;
          beat_cnt_d = '0;
          if (line_base == '0)        first_w_d   = cur_w;
          else if (cur_w != first_w_q) err_width_d = 1'b1;
        end else begin
          beat_cnt_d = cur_w;
        end
`endif
      end
    end

    if (state_d == IDLE) single_d = 1'b0;

    if (status_clear) begin
      fcnt_d      = '0;
      err_short_d = 1'b0;
      err_ovf_d   = 1'b0;
`ifdef FRAME_CAPTURE_CTRL_LINE_STATS_EN
      err_width_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      skip_q      <= 8'd0;
      line_q      <= '0;
      single_q    <= 1'b0;
      fcnt_q      <= '0;
      err_short_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      line_q      <= line_d;
      single_q    <= single_d;
      fcnt_q      <= fcnt_d;
      err_short_q <= err_short_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

`ifdef FRAME_CAPTURE_CTRL_LINE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q  <= '0;
      first_w_q   <= '0;
      last_w_q    <= '0;
      err_width_q <= 1'b0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      first_w_q   <= first_w_d;
      last_w_q    <= last_w_d;
      err_width_q <= err_width_d;
    end
  end

  assign last_width = last_w_q;
  assign err_width  = err_width_q;
`endif

  logic [DATA_W+1:0] out_data;

  axis_out_reg #(
    .W (DATA_W + 2)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data ({s_axis_tuser, s_axis_tlast, s_axis_tdata}),
    .ready     (m_axis_tready),
    .valid     (m_axis_tvalid),
    .data      (out_data),
    .full      (out_full)
  );

  assign m_axis_tuser = out_data[DATA_W+1];
  assign m_axis_tlast = out_data[DATA_W];
  assign m_axis_tdata = out_data[DATA_W-1:0];

  assign busy         = (state_q != IDLE);
  assign frame_count  = fcnt_q;
  assign err_short    = err_short_q;
  assign err_overflow = err_ovf_q;

endmodule
`default_nettype wire

// File: doc/frame_capture_ctrl.md
Name: frame_capture_ctrl

Overview:
Capture sequencer between the camera pixel front end (AXI4-Stream, no backpressure, tuser marks start of frame, tlast marks end of line) and the VDMA write channel.
- Starts and stops capture only on frame boundaries.
- Supports stop, continuous and single-shot modes, plus frame decimation.
- Re-registers the stream with a tready handshake.
- Reports frame count and sticky short-frame/overflow errors to the AXI-Lite register block.

Parameters:
DATA_W, 10, pixel width
LINE_CNT_W, 10, width of line counters and cfg_height
FCNT_W, 16, completed-frame counter width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
s_axis_tvalid  in  1  beat valid from pixel front end (cannot be stalled)
s_axis_tdata  in  DATA_W  pixel
s_axis_tuser  in  1  first pixel of frame
s_axis_tlast  in  1  last pixel of line
m_axis_tvalid  out  1  output beat valid
m_axis_tready  in  1  downstream ready
m_axis_tdata  out  DATA_W  pixel
m_axis_tuser  out  1  start of frame
m_axis_tlast  out  1  end of line
ctrl_mode  in  2  0=stop, 1=continuous, 2=single-shot, 3=stop
ctrl_start  in  1  one-cycle pulse that arms single-shot
cfg_height  in  LINE_CNT_W  lines per frame (0 treated as 1)
cfg_skip  in  8  frames dropped between captured frames
status_clear  in  1  clears sticky errors and frame_count
busy  out  1  state != IDLE
frame_count  out  FCNT_W  completed captured frames (wraps)
err_short  out  1  sticky: SOF arrived before cfg_height lines
err_overflow  out  1  sticky: beat arrived while output register full

Behaviour:
- Reset values: all outputs 0; state IDLE; skip_cnt 0; line_cnt 0.
- Accepted beat: s_axis_tvalid=1.
- Output register: a forwarded beat is loaded one cycle after acceptance (latency 1). It holds until m_axis_tvalid & m_axis_tready. A load and a drain in the same cycle is legal (throughput 1 beat/cycle).
- States:
  - IDLE: nothing forwarded.
    - ctrl_mode=1 -> WAIT_SOF.
    - ctrl_mode=2 & ctrl_start -> WAIT_SOF, single flag set.
    - Load skip_cnt=0 on leaving IDLE.
  - WAIT_SOF:
    - ctrl_mode in {0,3} -> IDLE, no SOF needed.
    - On SOF with skip_cnt==0: forward the beat, reload skip_cnt=cfg_skip, line_cnt=0 -> PASS.
    - On SOF with skip_cnt!=0: decrement skip_cnt, stay.
    - Non-SOF beats are discarded.
  - PASS: every beat is forwarded; line_cnt increments on tlast.
    - When tlast makes line_cnt reach cfg_height: frame complete. frame_count++, then -> IDLE if single or ctrl_mode!=1, else -> WAIT_SOF.
    - Mode changes in PASS take effect only at frame completion.
  - DROP: discard beats until next SOF, then apply the WAIT_SOF rules to that same beat.
- Short frame: SOF in PASS before completion sets err_short. The SOF is handled as in WAIT_SOF in the same cycle (the new frame may start immediately), and the aborted frame is not counted.
- Overflow: a beat to be forwarded arrives while m_axis_tvalid=1 and m_axis_tready=0.
  - Set err_overflow, drop that beat, go to DROP.
  - The held beat stays valid until taken.
  - The frame is not counted; no synthetic tlast is emitted.
- A beat that is both SOF and the completing tlast (cfg_height=1, width 1) completes the frame in that cycle.
- status_clear has priority over a same-cycle set; frame_count clears to 0.
- The single flag clears on return to IDLE.
- rst mid-frame returns to IDLE, clears the output register and all counters. The next capture resynchronises on SOF.

Optional Feature:
FRAME_CAPTURE_CTRL_LINE_STATS_EN
- Defined:
  - Adds outputs last_width[11:0] (beats in the most recent captured line) and err_width (sticky).
  - err_width is set when a line in a captured frame differs in length from the first line of that frame.
  - status_clear also clears err_width.
- Undefined: these ports and counters are absent.

Decomposition:
- Package frame_capture_pkg holds: state enum (IDLE, WAIT_SOF, PASS, DROP), mode constants (MODE_STOP, MODE_CONT, MODE_SINGLE), default widths.
- One sub-module, axis_out_reg: single-entry output register with load/drain and a full flag used for overflow detection.

Test Plan:
- mode=1, cfg_height=4, 8-pixel lines, tready=1, 3 frames:
  - Output starts at the first SOF; 96 beats, tuser on the 1st beat of each frame, tlast every 8th.
  - frame_count=3.
- Reset mid-line, then mode=1:
  - Remaining pixels of the running frame are discarded; the first output beat is the next SOF.
  - Output latency is 1 cycle.
- mode=2, ctrl_start once, 3 frames streamed:
  - Exactly frame 1 is forwarded; busy falls after its 4th tlast; frame_count=1.
- mode=1, cfg_skip=2, 7 frames:
  - Frames 1, 4, 7 are forwarded; frame_count=3.
- SOF after 2 of 4 lines:
  - err_short=1; the new frame is forwarded; frame_count counts only complete frames.
- tready held 0 for 3 cycles mid-line:
  - err_overflow=1, first held beat preserved.
  - Output resumes at the next SOF; status_clear returns err_overflow and frame_count to 0.
